// File: rtl/regfile_scoreboard.sv
// Register file with NREAD combinational read ports, one write port, a per-register
// pending scoreboard and a post-reset clear sequencer. Optional write-first bypass: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 16,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic                    ready,
   input  logic [NREAD*AW-1:0]     rdAddr,
   output logic [NREAD*XLEN-1:0]   rdData,
   output logic [NREAD-1:0]        rdPending,
   input  logic                    wrEn,
   input  logic [AW-1:0]           wrAddr,
   input  logic [XLEN-1:0]         wrData,
   input  logic                    rsvEn,
   input  logic [AW-1:0]           rsvAddr,
   output logic                    rsvBusy
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     clr_idx_q, clr_idx_d;
   logic              ready_q, ready_d;
   logic [NREGS-1:0]  pend_q, pend_d;
   logic [XLEN-1:0]   regs_q [NREGS];
   logic [XLEN-1:0]   regs_d [NREGS];

   // Register 0 and addresses past NREGS-1 are not real storage.
   function automatic logic valid_addr(input logic [AW-1:0] a);
      return (a != '0) && (32'(a) < NREGS);
   endfunction

   logic wr_ok, rsv_valid, rsv_ok;

   always_comb begin
      wr_ok     = (state_q == S_RUN) && wrEn && valid_addr(wrAddr);
      rsv_valid = valid_addr(rsvAddr);
      rsvBusy   = rsvEn && ready_q && rsv_valid && pend_q[rsvAddr] &&
                  !(wrEn && (wrAddr == rsvAddr));
      rsv_ok    = (state_q == S_RUN) && rsvEn && rsv_valid && !rsvBusy;
   end

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      ready_d   = ready_q;
      pend_d    = pend_q;
      regs_d    = regs_q;
      case (state_q)
         S_CLEAR: begin
            if (clr_idx_q != '0) regs_d[clr_idx_q] = '0;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREGS - 1)) begin
               state_d   = S_RUN;
               ready_d   = 1'b1;
               clr_idx_d = '0;
            end
         end
         S_RUN: begin
            if (wr_ok) begin
               regs_d[wrAddr] = wrData;
               pend_d[wrAddr] = 1'b0;
            end
            // Applied after the write so a same-address reserve leaves the bit set.
            if (rsv_ok) pend_d[rsvAddr] = 1'b1;
         end
         default: state_d = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= ready_d;
         pend_q    <= pend_d;
      end
   end

   // Array contents hold while reset is asserted.
   always_ff @(posedge clk) begin
      if (reset) regs_q <= regs_d;
   end

   assign ready = ready_q;

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            pend;

      assign addr = rdAddr[i*AW +: AW];

      always_comb begin
         data = '0;
         pend = 1'b0;
         if (ready_q && valid_addr(addr)) begin
            data = regs_q[addr];
            pend = pend_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wrAddr == addr)) begin
               data = wrData;
               pend = 1'b0;
            end
`endif
         end
      end

      assign rdData[i*XLEN +: XLEN] = data;
      assign rdPending[i]           = pend;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard against a rule-level array model.
module tb_regfile_scoreboard;
   localparam int XLEN = 32, NREGS = 16, NREAD = 2, AW = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  ready;
   logic [NREAD*AW-1:0]   rdAddr;
   logic [NREAD*XLEN-1:0] rdData;
   logic [NREAD-1:0]      rdPending;
   logic                  wrEn;
   logic [AW-1:0]         wrAddr;
   logic [XLEN-1:0]       wrData;
   logic                  rsvEn;
   logic [AW-1:0]         rsvAddr;
   logic                  rsvBusy;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
      .clk(clk), .reset(reset), .ready(ready),
      .rdAddr(rdAddr), .rdData(rdData), .rdPending(rdPending),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
      .rsvEn(rsvEn), .rsvAddr(rsvAddr), .rsvBusy(rsvBusy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_reg [NREGS];
   bit          m_pend [NREGS];
   bit          m_ready;
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_busy();
      return rsvEn && m_ready && (rsvAddr != 0) && m_pend[rsvAddr] &&
             !(wrEn && wrAddr == rsvAddr);
   endfunction

   function automatic logic [31:0] m_rd(input int a);
      if (!m_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (wrEn && wrAddr == a) return wrData;
`endif
      return m_reg[a];
   endfunction

   function automatic bit m_rp(input int a);
      if (!m_ready || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wrEn && wrAddr == a) return 1'b0;
`endif
      return m_pend[a];
   endfunction

   task automatic check_all(input string tag);
      int a0, a1;
      a0 = int'(rdAddr[AW-1:0]);
      a1 = int'(rdAddr[2*AW-1:AW]);
      chk({tag, ".ready"},   32'(ready),        32'(m_ready));
      chk({tag, ".rsvBusy"}, 32'(rsvBusy),      32'(m_busy()));
      chk({tag, ".rd0"},     rdData[31:0],      m_rd(a0));
      chk({tag, ".rd1"},     rdData[63:32],     m_rd(a1));
      chk({tag, ".rp0"},     32'(rdPending[0]), 32'(m_rp(a0)));
      chk({tag, ".rp1"},     32'(rdPending[1]), 32'(m_rp(a1)));
   endtask

   // Advance one clock, applying the rules to the model with the held inputs.
   task automatic tick();
      bit busy;
      @(posedge clk);
      busy = m_busy();
      if (!reset) begin
         m_ready = 0;
         m_cnt   = 0;
         foreach (m_pend[k]) m_pend[k] = 0;
      end else if (!m_ready) begin
         if (m_cnt != 0) m_reg[m_cnt] = 32'h0;
         if (m_cnt == NREGS - 1) m_ready = 1;
         m_cnt++;
      end else begin
         if (wrEn && wrAddr != 0) begin
            m_reg[wrAddr]  = wrData;
            m_pend[wrAddr] = 0;
         end
         if (rsvEn && rsvAddr != 0 && !busy) m_pend[rsvAddr] = 1;
      end
      #1;
   endtask

   task automatic idle();
      wrEn = 0; wrAddr = '0; wrData = '0; rsvEn = 0; rsvAddr = '0;
   endtask

   task automatic setrd(input int a0, input int a1);
      rdAddr = {AW'(a1), AW'(a0)};
   endtask

   initial begin
      foreach (m_reg[k]) begin m_reg[k] = 32'h0; m_pend[k] = 0; end
      m_ready = 0; m_cnt = 0;
      reset = 0; idle(); setrd(0, 0);

      // 1: reset 3 cycles, clear sequence with writes/reserves attempted
      repeat (3) tick();
      check_all("rst");
      reset = 1;
      wrEn = 1; wrAddr = 4'd3; wrData = 32'hFFFF_FFFF;
      rsvEn = 1; rsvAddr = 4'd6; setrd(3, 6);
      for (int i = 0; i < NREGS; i++) begin
         check_all("clear");
         tick();
      end
      idle();
      chk("ready_up", 32'(ready), 32'h1);
      for (int a = 0; a < NREGS; a++) begin
         setrd(a, NREGS - 1 - a);
         #1 check_all("zero");
      end

      // 2: basic write / reg0 write dropped
      wrEn = 1; wrAddr = 4'd5; wrData = 32'hDEAD_BEEF; tick(); idle();
      setrd(5, 5); #1 check_all("wr5");
      chk("wr5.abs", rdData[63:32], 32'hDEAD_BEEF);
      wrEn = 1; wrAddr = 4'd0; wrData = 32'h1234; tick(); idle();
      setrd(0, 5); #1 check_all("wr0");
      chk("wr0.abs", rdData[31:0], 32'h0);

      // 3: reserve, refused second reserve, release by write
      rsvEn = 1; rsvAddr = 4'd7; tick(); idle();
      setrd(7, 7); #1 check_all("rsv7");
      chk("rsv7.abs", 32'(rdPending[0]), 32'h1);
      rsvEn = 1; rsvAddr = 4'd7; #1 check_all("rsv7b");
      chk("rsv7b.abs", 32'(rsvBusy), 32'h1);
      tick(); idle();
      wrEn = 1; wrAddr = 4'd7; wrData = 32'h55; tick(); idle();
      #1 check_all("rel7");
      chk("rel7.abs", rdData[31:0], 32'h55);

      // 4: same-cycle write + reserve on a pending register
      rsvEn = 1; rsvAddr = 4'd3; tick(); idle();
      wrEn = 1; wrAddr = 4'd3; wrData = 32'hA; rsvEn = 1; rsvAddr = 4'd3; setrd(3, 7);
      #1 check_all("wrrsv3");
      chk("wrrsv3.busy", 32'(rsvBusy), 32'h0);
      tick(); idle();
      #1 check_all("wrrsv3n");
      chk("wrrsv3n.pend", 32'(rdPending[0]), 32'h1);

      // 5: read during write of the same register
      setrd(9, 9); wrEn = 1; wrAddr = 4'd9; wrData = 32'h77;
      #1 check_all("byp9");
`ifdef REGFILE_BYPASS_EN
      chk("byp9.abs", rdData[31:0], 32'h77);
`else
      chk("byp9.abs", rdData[31:0], 32'h0);
`endif
      tick(); idle();
      #1 check_all("byp9n");
      chk("byp9n.abs", rdData[31:0], 32'h77);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         wrEn    = ($urandom_range(0, 2) == 0);
         wrAddr  = AW'($urandom_range(0, NREGS - 1));
         wrData  = $urandom;
         rsvEn   = ($urandom_range(0, 2) == 0);
         rsvAddr = ($urandom_range(0, 3) == 0) ? wrAddr : AW'($urandom_range(0, NREGS - 1));
         setrd(($urandom_range(0, 3) == 0) ? int'(wrAddr) : $urandom_range(0, NREGS - 1),
               $urandom_range(0, NREGS - 1));
         #1 check_all("rand");
         tick();
      end
      idle();

      // 6: reset mid-RUN with r4 reserved, then mid-CLEAR at clrIdx=8
      rsvEn = 1; rsvAddr = 4'd4; tick(); idle();
      setrd(4, 4); #1 check_all("rsv4");
      reset = 0; tick(); reset = 1;
      repeat (8) begin check_all("clr8"); tick(); end
      reset = 0; tick(); reset = 1;
      for (int i = 0; i < NREGS; i++) begin
         check_all("reclear");
         tick();
      end
      check_all("rerun");
      chk("rerun.ready", 32'(ready), 32'h1);
      chk("rerun.pend4", 32'(rdPending[0]), 32'h0);
      for (int a = 0; a < NREGS; a++) begin
         setrd(a, a);
         #1 check_all("rezero");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
